// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants: default baud divider, counter widths and FSM state encodings.
package uart_rx_pkg;

    localparam int unsigned UART_DIV_RATE  = 260;
    localparam int unsigned UART_DIV_CNT_W = 9;
    localparam int unsigned UART_BIT_CNT_W = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling driven by a baud divider, break hold-off after a framing error.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_RATE  = UART_DIV_RATE,
    parameter int unsigned DIV_CNT_W = UART_DIV_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_busy,
    output logic       rx_end,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam logic [DIV_CNT_W-1:0] HALF_LOAD = DIV_CNT_W'(DIV_RATE / 2 - 1);
    localparam logic [DIV_CNT_W-1:0] FULL_LOAD = DIV_CNT_W'(DIV_RATE - 1);

    logic                      rx_s;
    logic [2:0]                state;
    logic [DIV_CNT_W-1:0]      div_cnt;
    logic [UART_BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]                shreg;
    logic                      tick;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_busy   <= 1'b0;
            rx_end    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_end    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        div_cnt <= HALF_LOAD;
                        rx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        div_cnt <= FULL_LOAD;
                        if (!rx_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        div_cnt        <= FULL_LOAD;
                        shreg[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + 1'b1;
                        if (bit_cnt == '1)
                            state <= ST_STOP;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        div_cnt <= FULL_LOAD;
                        if (rx_s) begin
                            rx_data <= shreg;
                            rx_end  <= 1'b1;
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                // A low line after a bad stop bit is a break, not a new start bit.
                ST_BREAK: begin
                    if (rx_s) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DIV_RATE, default 260, clocks per bit period (even, >=4).
REQ-002 Parameter: DIV_CNT_W, default 9, width of the baud divider counter (must hold DIV_RATE-1).
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Port: rx_busy  output  1  frame reception in progress (uart_ctrl status bit).
REQ-007 Port: rx_end  output  1  one-cycle pulse, valid byte on rx_data.
REQ-008 Port: rx_data  output  8  last correctly received byte.
REQ-009 Port: frame_err  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
REQ-011 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: rx_s==0 -> START, div_cnt loaded with DIV_RATE/2-1.
REQ-013 div_cnt SHALL decrement once per clock in START/DATA/STOP; a "tick" is div_cnt==0, which reloads DIV_RATE-1.
REQ-014 START tick: rx_s==0 -> DATA, bit_cnt=0; rx_s==1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA tick: rx_s shifted into shift register at bit position bit_cnt (LSB first); bit_cnt increments; tick with bit_cnt==7 -> STOP.
REQ-016 STOP tick, rx_s==1: rx_data <= shift register, rx_end=1 for the following cycle only, -> IDLE.
REQ-017 STOP tick, rx_s==0: frame_err=1 for one cycle, rx_data unchanged, rx_end stays 0, -> BREAK.
REQ-018 BREAK: remain until rx_s==1, then -> IDLE; no new start is detected while the line stays low.
REQ-019 rx_busy SHALL be 1 in START, DATA, STOP, BREAK; 0 in IDLE (registered, asserts the cycle after start detection).
REQ-020 Sample timing: data bit k sampled at DIV_RATE/2 + (k+1)*DIV_RATE clocks after the start-detect edge; stop bit sampled at DIV_RATE/2 + 9*DIV_RATE.
REQ-021 rx_data SHALL hold its value between rx_end pulses; it SHALL never show partial bytes.
REQ-022 A falling edge on rx during DATA/STOP SHALL be ignored (no resynchronisation mid-frame).
REQ-023 rx_end and frame_err SHALL never assert in the same cycle.
REQ-024 Back-to-back frames: a start bit beginning immediately after the stop-bit sample SHALL be detected with no lost frame.

Reset
REQ-025 On reset: state=IDLE, div_cnt=0, bit_cnt=0, shift register=0, rx_data=0x00, rx_busy=0, rx_end=0, frame_err=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_end/frame_err pulse; after release the block waits in IDLE for the next falling edge.

Structure
REQ-027 UART_DIV_RATE, UART_DIV_CNT_W, UART_BIT_CNT_W and the state encodings SHALL live in the shared uart.h header, alongside existing UART addresses.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, uart_sync (1-bit, reset value parameterised).
REQ-029 rx_busy, rx_end, rx_data SHALL connect directly to the same-named inputs of the UART control block; frame_err is routed for future status use.

Verification (DIV_RATE=16)
REQ-030 Frame 0xA5 with valid stop -> rx_end single pulse at cycle 153 after start detect (8+144+1), rx_data=0xA5, frame_err=0 throughout.
REQ-031 Low glitch of 4 clocks on idle line -> return to IDLE at first tick, rx_busy pulses ≤9 cycles, no rx_end, rx_data unchanged.
REQ-032 Frame 0x3C with stop bit low, line held low 100 clocks -> frame_err one pulse, rx_data keeps previous 0xA5, rx_busy high until line returns high, then next frame 0x01 received correctly.
REQ-033 Frames 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three rx_end pulses, data in order, no frame_err.
REQ-034 Reset asserted at data bit 4 of frame 0x81 -> all outputs 0 next cycle, no rx_end; subsequent frame 0x7E received correctly.
REQ-035 Baud skew ±3% on frame 0xC3 -> received correctly (mid-bit sampling margin).
